// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// default operand width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// One-bit full-adder cell; the only arithmetic element of the serial adder.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  // Sum and majority carry of the three input bits.
  always_comb begin
    s  = a ^ b ^ cin;
    co = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: sums two WIDTH-bit operands LSB-first through a single
// full-adder cell and a carry flip-flop, with valid/ready handshakes on both
// the operand and result sides.
// Optional feature: define SERIAL_ADDER_SUB_EN to add the sub port, which turns
// the block into a serial subtractor (a - b - cin, cout = borrow).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic             accept;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Only the upper WIDTH-1 result bits need to be held between shifts; the
  // final sum bit comes straight from the cell on the last SHIFT edge.
  logic [WIDTH-2:0] sum_sr;
  logic [WIDTH-1:0] sum_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last_bit;

  logic [WIDTH-1:0] b_load;
  logic             carry_load;
  logic             cout_next;

  logic             fa_s;
  logic             fa_co;

  full_adder_cell u_cell (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .cin (carry),
    .s   (fa_s),
    .co  (fa_co)
  );

  assign sum_next = {fa_s, sum_sr};
  assign last_bit = (cnt == LAST_CNT);

`ifdef SERIAL_ADDER_SUB_EN
  logic sub_q;

  // Subtraction is a + ~b + ~cin; the final carry is inverted into a borrow.
  assign b_load     = sub ? ~b : b;
  assign carry_load = cin ^ sub;
  assign cout_next  = fa_co ^ sub_q;
`else
  assign b_load     = b;
  assign carry_load = cin;
  assign cout_next  = fa_co;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state <= state_next;
    end
  end

  // Next-state logic and handshake/status decode from the state register.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a latch behind.
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        accept   = in_valid;
        if (in_valid) state_next = SHIFT;
      end
      SHIFT: begin
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: operand capture, one-bit-per-cycle shifting, result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this block holds only flip-flops (no memory array), so every
      // one is reset; an aborted operation can never leak a partial result.
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q  <= 1'b0;
`endif
    end else if (accept) begin
      a_sr   <= a;
      b_sr   <= b_load;
      carry  <= carry_load;
      cnt    <= '0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q  <= sub;
`endif
    end else if (state == SHIFT) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      sum_sr <= sum_next[WIDTH-1:1];
      carry  <= fa_co;
      cnt    <= cnt + CW'(1);
      if (last_bit) begin
        sum  <= sum_next;
        cout <= cout_next;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed scenarios plus randomized
// operands compared against plain-arithmetic a + b + cin (or a - b - cin when
// SERIAL_ADDER_SUB_EN is defined).
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int checks = 0;
  int failures = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: exact (W+1)-bit result {cout,sum}.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic s);
    logic [W:0] r;
    if (s) begin
      // a - b - cin; top bit of the (W+1)-bit difference is the borrow.
      r = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
    end else begin
      r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    end
    return r;
  endfunction

  // Drive one full transaction; lat is the number of edges from acceptance to
  // out_valid, or -1 if out_valid never appeared within the budget.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        input logic sv, input int hold,
                        output logic [W-1:0] s, output logic c, output int lat);
    @(negedge clk);
    a = av; b = bv; cin = cv; sub = sv;
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = $urandom_range(0, 1);
    lat = 0;
    while (!out_valid && lat < W + 20) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
    s = sum; c = cout;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, cout, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, {W{1'b0}}}) begin
      failures++;
      $display("FAIL reset_state: got rdy=%b vld=%b busy=%b cout=%b sum=%h, want 1 0 0 0 00",
               in_ready, out_valid, busy, cout, sum);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [W-1:0] s; logic c; int lat;
    run_op(8'h35, 8'h4A, 1'b0, 1'b0, 0, s, c, lat);
    checks++;
    if (lat !== W) begin
      failures++;
      $display("FAIL basic_latency: got %0d want %0d", lat, W);
    end
    checks++;
    if ({c, s} !== 9'h07F) begin
      failures++;
      $display("FAIL basic_sum: got cout=%b sum=%h want cout=0 sum=7f", c, s);
    end
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle_after: got rdy=%b busy=%b want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_carry;
    logic [W-1:0] s; logic c; int lat;
    run_op(8'hFF, 8'h01, 1'b1, 1'b0, 0, s, c, lat);
    checks++;
    if ({c, s} !== 9'h101 || lat !== W) begin
      failures++;
      $display("FAIL carry_ff_01_1: got cout=%b sum=%h lat=%0d want 1 01 %0d", c, s, lat, W);
    end
    run_op(8'hFF, 8'h00, 1'b1, 1'b0, 0, s, c, lat);
    checks++;
    if ({c, s} !== 9'h100 || lat !== W) begin
      failures++;
      $display("FAIL carry_ff_00_1: got cout=%b sum=%h lat=%0d want 1 00 %0d", c, s, lat, W);
    end
  endtask

  task automatic test_backpressure;
    logic [W-1:0] s0; logic c0; int lat;
    logic [W:0] exp;
    exp = ref_add(8'h5C, 8'h77, 1'b1, 1'b0);
    @(negedge clk);
    a = 8'h5C; b = 8'h77; cin = 1'b1; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < W + 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (!out_valid || {cout, sum} !== exp) begin
      failures++;
      $display("FAIL bp_result: got vld=%b cout=%b sum=%h want 1 %b %h",
               out_valid, cout, sum, exp[W], exp[W-1:0]);
    end
    s0 = sum; c0 = cout;
    for (int i = 0; i < 5; i++) begin
      a = $urandom; b = $urandom; cin = $urandom_range(0, 1);
      in_valid = (i % 2 == 0);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 ||
          sum !== s0 || cout !== c0) begin
        failures++;
        $display("FAIL bp_hold_%0d: got vld=%b rdy=%b busy=%b cout=%b sum=%h want 1 0 1 %b %h",
                 i, out_valid, in_ready, busy, cout, sum, c0, s0);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_release: got vld=%b rdy=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
    end
    // Ignored operands must not have started a second operation.
    repeat (W + 2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || sum !== s0 || cout !== c0) begin
      failures++;
      $display("FAIL bp_no_extra: got busy=%b vld=%b cout=%b sum=%h want 0 0 %b %h",
               busy, out_valid, cout, sum, c0, s0);
    end
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] s; logic c; int lat;
    @(negedge clk);
    a = 8'hC3; b = 8'h5A; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({in_ready, out_valid, busy, cout, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, {W{1'b0}}}) begin
        failures++;
        $display("FAIL reset_mid_%0d: got rdy=%b vld=%b busy=%b cout=%b sum=%h want 1 0 0 0 00",
                 i, in_ready, out_valid, busy, cout, sum);
      end
      @(negedge clk);
    end
    rst_n = 1'b1;
    run_op(8'h10, 8'h22, 1'b0, 1'b0, 0, s, c, lat);
    checks++;
    if ({c, s} !== 9'h032 || lat !== W) begin
      failures++;
      $display("FAIL reset_mid_next: got cout=%b sum=%h lat=%0d want 0 32 %0d", c, s, lat, W);
    end
  endtask

  task automatic test_streaming;
    logic [W:0] expq[$];
    int hs[$];
    int cyc = 0;
    int issued = 0;
    int got = 0;
    bit just_hs = 0;
    logic [W:0] e;
    @(negedge clk);
    a = $urandom; b = $urandom; cin = $urandom_range(0, 1); sub = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    while (got < 4 && cyc < 200) begin
      just_hs = 0;
      if (out_valid) begin
        e = (expq.size() > 0) ? expq.pop_front() : 'x;
        got++;
        checks++;
        if ({cout, sum} !== e) begin
          failures++;
          $display("FAIL stream_result_%0d: got cout=%b sum=%h want %b %h",
                   got, cout, sum, e[W], e[W-1:0]);
        end
      end
      if (in_ready && in_valid) begin
        expq.push_back(ref_add(a, b, cin, 1'b0));
        hs.push_back(cyc);
        issued++;
        just_hs = 1;
      end
      @(negedge clk);
      cyc++;
      if (just_hs) begin
        if (issued == 4) in_valid = 1'b0;
        else begin
          a = $urandom; b = $urandom; cin = $urandom_range(0, 1);
        end
      end
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (got !== 4) begin
      failures++;
      $display("FAIL stream_count: got %0d results want 4 (timeout)", got);
    end
    for (int i = 1; i < hs.size(); i++) begin
      checks++;
      if (hs[i] - hs[i-1] !== W + 2) begin
        failures++;
        $display("FAIL stream_interval_%0d: got %0d want %0d", i, hs[i] - hs[i-1], W + 2);
      end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] s; logic c; int lat;
    logic [W-1:0] av, bv; logic cv;
    logic [W:0] e;
    for (int i = 0; i < 16; i++) begin
      av = $urandom; bv = $urandom; cv = $urandom_range(0, 1);
      e = ref_add(av, bv, cv, 1'b0);
      run_op(av, bv, cv, 1'b0, $urandom_range(0, 3), s, c, lat);
      checks++;
      if ({c, s} !== e || lat !== W) begin
        failures++;
        $display("FAIL random_%0d: %h+%h+%b got cout=%b sum=%h lat=%0d want %b %h %0d",
                 i, av, bv, cv, c, s, lat, e[W], e[W-1:0], W);
      end
    end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub;
    logic [W-1:0] s; logic c; int lat;
    logic [W-1:0] av, bv; logic cv, sv;
    logic [W:0] e;
    run_op(8'h10, 8'h20, 1'b0, 1'b1, 0, s, c, lat);
    checks++;
    if ({c, s} !== 9'h1F0) begin
      failures++;
      $display("FAIL sub_10_20_0: got cout=%b sum=%h want 1 f0", c, s);
    end
    run_op(8'h20, 8'h10, 1'b1, 1'b1, 0, s, c, lat);
    checks++;
    if ({c, s} !== 9'h00F) begin
      failures++;
      $display("FAIL sub_20_10_1: got cout=%b sum=%h want 0 0f", c, s);
    end
    for (int i = 0; i < 8; i++) begin
      av = $urandom; bv = $urandom; cv = $urandom_range(0, 1); sv = $urandom_range(0, 1);
      e = ref_add(av, bv, cv, sv);
      run_op(av, bv, cv, sv, 0, s, c, lat);
      checks++;
      if ({c, s} !== e) begin
        failures++;
        $display("FAIL sub_random_%0d: sub=%b %h,%h,%b got cout=%b sum=%h want %b %h",
                 i, sv, av, bv, cv, c, s, e[W], e[W-1:0]);
      end
    end
    sub = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_reset_mid();
    test_streaming();
    test_random();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
